// File: rtl/buck_pkg.sv
// rtl/buck_pkg.sv - channel indices, sequencer state encoding and channel-selection helpers
package buck_pkg;

   localparam logic [1:0] CH_IIN  = 2'd0;
   localparam logic [1:0] CH_VIN  = 2'd1;
   localparam logic [1:0] CH_IOUT = 2'd2;
   localparam logic [1:0] CH_VOUT = 2'd3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_UPDATE = 3'd3;
   localparam logic [2:0] ST_NEXT   = 3'd4;

   // Lowest set mask bit at or above 'from', wrapping past channel 3.
   function automatic logic [1:0] next_ch(input logic [3:0] mask, input logic [1:0] from);
      logic [1:0] c;
      logic [1:0] r;
      logic       found;
      r     = from;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         c = from + 2'(k);
         if (!found && mask[c]) begin
            r     = c;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] high_ch(input logic [3:0] mask);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) r = 2'(k);
      end
      return r;
   endfunction

endpackage

// File: rtl/buck_meas_accum.sv
// rtl/buck_meas_accum.sv - per-visit sample accumulator, sample counter and left-aligned average
module buck_meas_accum #(
   parameter int ADC_W    = 12,
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             add,
   input  logic [ADC_W-1:0] data,
   output logic             last,
   output logic [15:0]      aligned
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic [CNT_W-1:0] cnt;
   logic [ADC_W-1:0] avg;

   // The average includes the sample being added so the result can be
   // registered on the same edge that accepts the final conversion.
   assign sum     = acc + ACC_W'(data);
   assign avg     = ADC_W'(sum >> AVG_LOG2);
   assign aligned = 16'(avg) << (16 - ADC_W);
   assign last    = (cnt == CNT_W'((1 << AVG_LOG2) - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (add) begin
         acc <= sum;
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/buck_meas_sequencer.sv
// rtl/buck_meas_sequencer.sv - round-robin buck ADC sequencer with per-channel averaging and timeout
module buck_meas_sequencer
   import buck_pkg::*;
#(
   parameter int ADC_W    = 12,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic             en,
   input  logic [3:0]       ch_mask,
   input  logic             err_clr,
   output logic             adc_start,
   output logic [1:0]       adc_ch,
   input  logic             adc_done,
   input  logic [ADC_W-1:0] adc_data,
   output logic [15:0]      input_current,
   output logic [15:0]      input_voltage,
   output logic [15:0]      output_current,
   output logic [15:0]      output_voltage,
   output logic             meas_strobe,
   output logic [1:0]       meas_ch,
   output logic             frame_done,
   output logic             err_timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [2:0]    state;
   logic [1:0]    idx;
   logic [3:0]    mask_q;
   logic [TW-1:0] tcnt;
   logic          accept;
   logic          expire;
   logic          acc_clear;
   logic          acc_last;
   logic [15:0]   aligned;

   // A done in the expiry cycle is still accepted: expire requires !adc_done.
   assign accept    = (state == ST_WAIT) && adc_done;
   assign expire    = (state == ST_WAIT) && !adc_done && (tcnt == TW'(TIMEOUT));
   assign acc_clear = (state == ST_IDLE) || (state == ST_NEXT);

   buck_meas_accum #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_accum (
      .clk     (pclk),
      .rst     (preset),
      .clear   (acc_clear),
      .add     (accept),
      .data    (adc_data),
      .last    (acc_last),
      .aligned (aligned)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state  <= ST_IDLE;
         idx    <= 2'd0;
         mask_q <= 4'd0;
         tcnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en && |ch_mask) begin
                  mask_q <= ch_mask;
                  idx    <= next_ch(ch_mask, idx);
                  state  <= ST_START;
               end
            end
            ST_START: begin
               tcnt  <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (accept) begin
                  // Losing enable abandons the visit; IDLE clears the partial sum.
                  if (!en)
                     state <= ST_IDLE;
                  else if (acc_last)
                     state <= ST_UPDATE;
                  else
                     state <= ST_START;
               end else if (expire) begin
                  state <= ST_NEXT;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            ST_UPDATE: state <= ST_NEXT;
            ST_NEXT: begin
               mask_q <= ch_mask;
               if (|ch_mask)
                  idx <= next_ch(ch_mask, idx + 2'd1);
               state <= (en && |ch_mask) ? ST_START : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         input_current  <= 16'd0;
         input_voltage  <= 16'd0;
         output_current <= 16'd0;
         output_voltage <= 16'd0;
         err_timeout    <= 1'b0;
      end else begin
         if (accept && en && acc_last) begin
            case (idx)
               CH_IIN:  input_current  <= aligned;
               CH_VIN:  input_voltage  <= aligned;
               CH_IOUT: output_current <= aligned;
               CH_VOUT: output_voltage <= aligned;
               default: ;
            endcase
         end
         err_timeout <= expire | (err_timeout & ~err_clr);
      end
   end

   assign adc_start   = (state == ST_START);
   assign adc_ch      = idx;
   assign meas_strobe = (state == ST_UPDATE);
   assign meas_ch     = meas_strobe ? idx : 2'd0;
   assign frame_done  = meas_strobe && (idx == high_ch(mask_q));

endmodule
